// File: rtl/paper_cpu_ctrl.sv
// rtl/paper_cpu_ctrl.sv - fetch/execute sequencer for the paper processor (INC/JNO/HLT)
module paper_cpu_ctrl #(
    parameter int ACC_W  = 2,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_OPERAND = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]         ir_q, ir_d;
    logic               ovf_q, ovf_d;
    logic               illegal_q, illegal_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ACC_W:0]     acc_sum;

    // pc wrap is plain modular arithmetic; the carry out of acc becomes ovf
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = mem_data;
                pc_d    = pc_inc;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir_q)
                    OP_INC: begin
                        {ovf_d, acc_d} = acc_sum;
                        state_d        = S_FETCH;
                    end
                    OP_JNO:  state_d = S_OPERAND;
                    OP_HLT:  state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_OPERAND: begin
                // operand word sits at pc; skip over it when the jump is not taken
                pc_d    = ovf_q ? pc_inc : mem_data[ADDR_W-1:0];
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            acc_q     <= '0;
            ir_q      <= '0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            ir_q      <= ir_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign acc      = acc_q;
    assign ovf      = ovf_q;
    assign illegal  = illegal_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_OPERAND);
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_paper_cpu_ctrl.sv
// tb/tb_paper_cpu_ctrl.sv - self-checking bench for paper_cpu_ctrl
module tb_paper_cpu_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] mem_addr;
    logic [1:0] mem_data;
    logic [1:0] acc;
    logic       ovf;
    logic [1:0] pc;
    logic       busy;
    logic       halted;
    logic       illegal;

    logic [7:0] prog;
    int total;
    int bad;

    typedef struct {
        logic [7:0] prog;
        int         cycles;
        logic [1:0] acc;
        logic       ovf;
        logic [1:0] pc;
        logic       ill;
        int         ignore_at;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];

    paper_cpu_ctrl #(.ACC_W(2), .ADDR_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .acc      (acc),
        .ovf      (ovf),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    assign mem_data = prog[2*mem_addr +: 2];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Pulses start, optionally re-pulses it while busy, waits for HALT and scores the run.
    task automatic run_vec(input vec_t v, input bit trace);
        vec_t e;
        int   n;
        prog = v.prog;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!halted && n < 100) begin
            if (n == v.ignore_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n++;
            if (n == 1) check("busy_in_run", int'(busy), 1);
            if (trace && (n == 2 || n == 7 || n == 12 || n == 17)) begin
                check("trace_acc", int'(acc), (n / 5 + 1) % 4);
                check("trace_ovf", int'(ovf), (n == 17) ? 1 : 0);
            end
        end
        e = exp_q.pop_front();
        check("halt_cycles", n, e.cycles);
        check("acc", int'(acc), int'(e.acc));
        check("ovf", int'(ovf), int'(e.ovf));
        check("pc", int'(pc), int'(e.pc));
        check("mem_addr", int'(mem_addr), int'(e.pc));
        check("illegal", int'(illegal), int'(e.ill));
        check("busy_at_halt", int'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_acc"}, int'(acc), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
        check({tag, "_pc"}, int'(pc), 0);
        check({tag, "_mem_addr"}, int'(mem_addr), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_halted"}, int'(halted), 0);
        check({tag, "_illegal"}, int'(illegal), 0);
    endtask

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;
        total   = 0;
        bad     = 0;
        prog    = 8'h00;

        //           prog {w3,w2,w1,w0}          cyc acc  ovf   pc    ill  ignore_at
        vecs[0] = '{{2'b10,2'b00,2'b01,2'b00}, 22, 2'd0, 1'b1, 2'd0, 1'b0, -1};
        vecs[1] = '{{2'b10,2'b00,2'b01,2'b00}, 22, 2'd0, 1'b1, 2'd0, 1'b0, 8};
        vecs[2] = '{{2'b00,2'b00,2'b11,2'b00},  4, 2'd1, 1'b0, 2'd2, 1'b1, -1};
        vecs[3] = '{{2'b10,2'b00,2'b11,2'b01},  5, 2'd0, 1'b0, 2'd0, 1'b0, -1};
        vecs[4] = '{{2'b00,2'b00,2'b00,2'b10},  2, 2'd0, 1'b0, 2'd1, 1'b0, -1};
        vecs[5] = '{{2'b10,2'b00,2'b00,2'b00},  8, 2'd3, 1'b0, 2'd0, 1'b0, 1};
        vecs[6] = '{{2'b00,2'b00,2'b00,2'b11},  2, 2'd0, 1'b0, 2'd1, 1'b1, -1};
        vecs[7] = '{{2'b00,2'b00,2'b00,2'b10},  2, 2'd0, 1'b0, 2'd1, 1'b0, -1};

        // reset held: start toggling must have no effect
        repeat (3) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        check_zero("in_reset");
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_zero("after_reset");

        // first looping run also checks the acc/ovf trace; later runs restart from HALT
        run_vec(vecs[0], 1'b1);
        for (int i = 1; i < 8; i++) run_vec(vecs[i], 1'b0);

        // asynchronous reset during OPERAND of the second loop iteration
        prog = vecs[0].prog;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset_acc", int'(acc), 2);
        check("pre_reset_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk) reset_n = 1'b1;
        run_vec(vecs[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paper_cpu_ctrl.md
Name: paper_cpu_ctrl

Overview:
- Fetch/execute sequencer for the paper processor.
- Drives the address of the 2-bit instruction store, which answers combinationally, and executes the INC/JNO/HLT instruction set against an internal accumulator.
- Exposes run status and architectural state to the surrounding top level and the testbench.

Parameters:
ACC_W, 2, accumulator width in bits; overflow is the carry out of bit ACC_W-1.
ADDR_W, 2, instruction address width; must be ≤ 2 because JNO operands are 2-bit data words.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; starts or restarts execution from address 0.
mem_addr  output  ADDR_W  address to the instruction store.
mem_data  input  2  instruction or operand word returned for mem_addr in the same cycle.
acc  output  ACC_W  accumulator.
ovf  output  1  overflow flag from the last INC.
pc  output  ADDR_W  program counter.
busy  output  1  high while in FETCH, EXEC or OPERAND.
halted  output  1  high in HALT.
illegal  output  1  set when opcode 11 is executed.

Behaviour:
- Encoding: INC=00, JNO=01 (followed by a 2-bit target word), HLT=10, 11=illegal.
- Reset, asynchronous on reset_n low: state=IDLE; pc, acc, ir, mem_addr = 0; ovf, busy, halted, illegal = 0.
- A reset asserted mid-operation aborts immediately to these values; no partial update survives.
- mem_addr is registered-free: it equals pc in every state.
- FSM, one state per clock:
  - IDLE: wait for start. On start: pc<=0, acc<=0, ovf<=0, illegal<=0, go to FETCH.
  - FETCH: ir<=mem_data; pc<=pc+1 (wraps modulo 2^ADDR_W); go to EXEC.
  - EXEC, ir=00: {ovf,acc}<=acc+1, so acc wraps to 0 with ovf=1; go to FETCH.
  - EXEC, ir=01: go to OPERAND; acc and ovf are unchanged.
  - EXEC, ir=10: go to HALT.
  - EXEC, ir=11: illegal<=1; go to HALT.
  - OPERAND: if ovf=0, pc<=mem_data[ADDR_W-1:0]; else pc<=pc+1 (wraps). Go to FETCH.
  - HALT: hold all state. start causes the same actions as start in IDLE.
- start in FETCH, EXEC or OPERAND is ignored; there is no mid-program restart except via reset.
- ovf is sticky between INCs: only INC writes it, and start clears it.
- pc wrap from 2^ADDR_W-1 to 0 is legal and silent, in both FETCH and OPERAND.
- busy = state ∈ {FETCH, EXEC, OPERAND}; halted = (state==HALT). Both are decoded from registered state.
- Timing: INC costs 2 cycles, JNO 3 cycles, HLT 2 cycles to reach HALT.

Test Plan:
- Reset: hold reset_n low, toggle clk and start -> all outputs 0 and state IDLE. Release reset -> outputs stay 0 until start.
- Program {00,01,00,10}, pulse start -> acc steps 1,2,3,0. ovf=1 only after the 4th INC. halted rises on the 22nd rising edge after the edge sampling start. Final pc=0 after HLT fetch wrap, acc=0, illegal=0.
- Restart from HALT: after the previous run, pulse start -> acc=0, ovf=0, identical 22-cycle run. start pulsed while busy -> no effect; the run completes in 22 cycles.
- Program {00,11,xx,xx} -> acc=1 after EXEC of INC, illegal=1, halted high 4 edges after start.
- Program {01,03,00,10} with ovf=0 -> JNO jumps to 3, HLT at 3. halted on edge 5, acc=0, pc=0 (wrapped).
- Reset mid-run: assert reset_n low asynchronously during OPERAND of the looping program -> outputs 0 immediately, before the next clk edge. After release, start reproduces the full 22-cycle run.
